// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with two-flop synchroniser, glitch-rejecting start detect and 3-sample majority voting.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_rdy,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      dout_q, dout_d;
    logic            dout_rdy_q, dout_rdy_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;
    logic            rx_meta_q, rx_s_q;
    logic [2:0]      hist_q, hist_d;
    logic            vote;

    assign hist_d = {hist_q[1:0], rx_s_q};
    assign vote   = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        dout_rdy_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE:      state_d = rx_s_q ? IDLE : START;
            START: begin
                if (cnt_q == HALF_LAST) begin
                    state_d   = vote ? IDLE : DATA;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shreg_d   = {vote, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    state_d   = (bit_idx_q == 3'd7) ? STOP : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    state_d     = vote ? IDLE : WAIT_IDLE;
                    dout_d      = vote ? shreg_q : dout_q;
                    dout_rdy_d  = vote;
                    frame_err_d = !vote;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: state_d = rx_s_q ? IDLE : WAIT_IDLE;
            default:   state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Line-side flops reset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            dout_q      <= '0;
            dout_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            hist_q      <= 3'b111;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            dout_rdy_q  <= dout_rdy_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            hist_q      <= hist_d;
        end
    end

    assign dout      = dout_q;
    assign dout_rdy  = dout_rdy_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and hand-written frame tests with an expected-byte scoreboard.
module tb_uart_rx;
    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [7:0] exp_dout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] dout;
    logic       dout_rdy, frame_err, busy;

    int         checks = 0, failures = 0;
    int         rdy_cnt = 0, fe_cnt = 0, cyc = 0;
    int         rdy_cyc[$];
    logic [7:0] exp_q[$];
    vec_t       vecs[4];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .dout(dout), .dout_rdy(dout_rdy), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dout_rdy === 1'b1) begin
            rdy_cnt++;
            rdy_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy actual dout=%0h required no strobe", dout);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
            check("busy_at_rdy", busy, 0);
        end
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic send(input logic [7:0] d, input logic stop, input int spike_bit);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < CPB; c++) begin
                rx = (i == spike_bit + 1 && c == 6) ? ~f[i] : f[i];
                @(negedge clk);
            end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 40, 8'hA5};
        vecs[1] = '{8'h00, 0, 8'h00};
        vecs[2] = '{8'hFF, 0, 8'hFF};
        vecs[3] = '{8'h3C, 40, 8'h3C};

        @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rdy", dout_rdy, 0);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_dout", dout, 8'h00);
        check("idle_rdy_cnt", rdy_cnt, 0);
        check("idle_fe_cnt", fe_cnt, 0);
        check("idle_busy", busy, 0);

        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(vecs[v].exp_dout);
            send(vecs[v].data, 1'b1, -1);
            repeat (vecs[v].gap) @(negedge clk);
        end
        drain();
        check("table_rdy_cnt", rdy_cnt, 4);
        check("table_fe_cnt", fe_cnt, 0);
        if (rdy_cyc.size() == 4) begin
            check("b2b_gap1", rdy_cyc[2] - rdy_cyc[1], 160);
            check("b2b_gap2", rdy_cyc[3] - rdy_cyc[2], 160);
        end else begin
            check("rdy_cyc_size", rdy_cyc.size(), 4);
        end

        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_hi", busy, 1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_lo", busy, 0);
        check("glitch_rdy_cnt", rdy_cnt, 4);
        check("glitch_fe_cnt", fe_cnt, 0);
        check("glitch_dout", dout, 8'h3C);

        send(8'h55, 1'b0, -1);
        repeat (100) @(negedge clk);
        check("break_fe_cnt", fe_cnt, 1);
        check("break_busy", busy, 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("break_fe_cnt_after", fe_cnt, 1);
        check("break_busy_lo", busy, 0);
        check("break_dout", dout, 8'h3C);
        check("break_rdy_cnt", rdy_cnt, 4);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1, -1);
        repeat (20) @(negedge clk);
        drain();

        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b1, 0);
        repeat (20) @(negedge clk);
        drain();

        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            rx = b[0];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_dout", dout, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_rdy_cnt", rdy_cnt, 6);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1, -1);
        repeat (20) @(negedge clk);
        drain();
        check("final_rdy_cnt", rdy_cnt, 7);
        check("final_fe_cnt", fe_cnt, 1);
        check("final_dout", dout, 8'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
